// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared constants for the SpaceInvaders game sequencer:
//                FSM state encodings, score/lives widths, saturating add.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DYING = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int SCORE_W   = 12;
  localparam int SCORE_MAX = 999;
  localparam int LIVES_W   = 2;
  localparam int CNT_W     = 8;

  // Add with clamp at lim; one extra bit keeps the sum from wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] inc,
                                                 input logic [SCORE_W-1:0] lim);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return (sum > {1'b0, lim}) ? lim : sum[SCORE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : One-cycle pulse per VGA frame. The raster match holds for two
//                clk cycles (pixel clock is clk/2), so only its rising edge is
//                turned into a tick, registered one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen #(
  parameter int FRAME_LINE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic       frame_tick
);

  logic w_cmp;
  logic r_cmp_d;
  logic r_tick;

  assign w_cmp      = (v_counter == 10'(FRAME_LINE)) && (h_counter == 10'd0);
  assign frame_tick = r_tick;

  // Remember last raster match and emit a pulse on its rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmp_d <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cmp_d <= w_cmp;
      r_tick  <= w_cmp & ~r_cmp_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : game_controller
//  Description : SpaceInvaders game sequencer: attract/play/death/game-over
//                FSM, score and record, lives, alien march schedule, start
//                button synchroniser and per-frame tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_controller #(
  parameter int LIVES_INIT        = 3,
  parameter int SCORE_MAX         = game_pkg::SCORE_MAX,
  parameter int POINTS_PER_HIT    = 10,
  parameter int FRAME_LINE        = 480,
  parameter int DEATH_FRAMES      = 60,
  parameter int MARCH_START       = 32,
  parameter int MARCH_MIN         = 4,
  parameter int MARCH_DEC         = 2,
  parameter int KILLS_PER_SPEEDUP = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    h_counter,
  input  logic [9:0]                    v_counter,
  input  logic                          btn_start,
  input  logic                          hit_alien,
  input  logic                          player_hit,
  input  logic                          aliens_landed,
  input  logic                          wave_cleared,
  output logic [1:0]                    state,
  output logic                          game_active,
  output logic                          freeze,
  output logic                          frame_tick,
  output logic                          march_step,
  output logic                          wave_reset,
  output logic [game_pkg::LIVES_W-1:0]  lives,
  output logic [game_pkg::SCORE_W-1:0]  pontuacao,
  output logic [game_pkg::SCORE_W-1:0]  record
);
  import game_pkg::*;

  logic [1:0]         r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_record;
  logic [LIVES_W-1:0] r_lives;
  logic [CNT_W-1:0]   r_march_cnt;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_kills;
  logic [CNT_W-1:0]   r_death_cnt;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync3;
  logic               r_march_step;
  logic               r_wave_reset;
  logic               w_tick;
  logic               w_start;
  logic [CNT_W-1:0]   w_period_dec;
  logic [SCORE_W-1:0] w_score_inc;

  frame_tick_gen #(
    .FRAME_LINE (FRAME_LINE)
  ) u_frame_tick (
    .clk        (clk),
    .reset      (reset),
    .h_counter  (h_counter),
    .v_counter  (v_counter),
    .frame_tick (w_tick)
  );

  // Start event fires once on the synchronised rising edge of the button.
  assign w_start      = r_sync2 & ~r_sync3;
  assign w_period_dec = (r_period >= CNT_W'(MARCH_MIN + MARCH_DEC))
                        ? (r_period - CNT_W'(MARCH_DEC)) : CNT_W'(MARCH_MIN);
  assign w_score_inc  = sat_add(r_score, SCORE_W'(POINTS_PER_HIT), SCORE_W'(SCORE_MAX));

  assign state       = r_state;
  assign game_active = (r_state == ST_PLAY);
  assign freeze      = (r_state == ST_DYING);
  assign frame_tick  = w_tick;
  assign march_step  = r_march_step;
  assign wave_reset  = r_wave_reset;
  assign lives       = r_lives;
  assign pontuacao   = r_score;
  assign record      = r_record;

  // Two-flop synchroniser for the asynchronous start button plus edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= btn_start;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Game FSM with score, lives, march scheduling and death timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_score      <= '0;
      r_record     <= '0;
      r_lives      <= LIVES_W'(LIVES_INIT);
      r_march_cnt  <= '0;
      r_period     <= CNT_W'(MARCH_START);
      r_kills      <= '0;
      r_death_cnt  <= '0;
      r_march_step <= 1'b0;
      r_wave_reset <= 1'b0;
    end else begin
      r_march_step <= 1'b0;
      r_wave_reset <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          // Score is frozen while OVER, so comparing every cycle equals comparing on entry.
          if ((r_state == ST_OVER) && (r_score > r_record))
            r_record <= r_score;
          if (w_start) begin
            r_state      <= ST_PLAY;
            r_score      <= '0;
            r_lives      <= LIVES_W'(LIVES_INIT);
            r_kills      <= '0;
            r_period     <= CNT_W'(MARCH_START);
            r_march_cnt  <= '0;
            r_wave_reset <= 1'b1;
          end
        end
        ST_PLAY: begin
          // Use >= so a shortened period fires on the next tick if already overdue.
          if (w_tick) begin
            if (r_march_cnt >= (r_period - CNT_W'(1))) begin
              r_march_step <= 1'b1;
              r_march_cnt  <= '0;
            end else begin
              r_march_cnt  <= r_march_cnt + CNT_W'(1);
            end
          end
          if (hit_alien) begin
            r_score <= w_score_inc;
            if (r_kills == CNT_W'(KILLS_PER_SPEEDUP - 1)) begin
              r_kills  <= '0;
              r_period <= w_period_dec;
            end else begin
              r_kills  <= r_kills + CNT_W'(1);
            end
          end
          // A new wave overrides any speed-up or march update of the same cycle.
          if (wave_cleared) begin
            r_wave_reset <= 1'b1;
            r_period     <= CNT_W'(MARCH_START);
            r_march_cnt  <= '0;
            r_kills      <= '0;
          end
          if (aliens_landed) begin
            r_lives <= '0;
            r_state <= ST_OVER;
          end else if (player_hit) begin
            r_lives     <= r_lives - LIVES_W'(1);
            r_state     <= ST_DYING;
            r_death_cnt <= '0;
          end
        end
        default: begin
          if (w_tick) begin
            if (r_death_cnt == CNT_W'(DEATH_FRAMES - 1)) begin
              if (r_lives == '0) begin
                r_state <= ST_OVER;
              end else begin
                r_state     <= ST_PLAY;
                r_march_cnt <= '0;
              end
            end else begin
              r_death_cnt <= r_death_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_controller
//  Description : Directed sequence plus randomized traffic for game_controller,
//                checked every cycle against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_controller;

  localparam int FP = 10;   // clk cycles per synthetic VGA frame

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_counter, v_counter;
  logic        btn_start, hit_alien, player_hit, aliens_landed, wave_cleared;
  logic [1:0]  state;
  logic        game_active, freeze, frame_tick, march_step, wave_reset;
  logic [1:0]  lives;
  logic [11:0] pontuacao, record;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the game (current visible values).
  int m_state, m_score, m_rec, m_lives, m_kills, m_period, m_since, m_dframes;
  bit m_tick, m_step, m_wr;
  bit bh1, bh2, bh3;        // button level 1, 2, 3 cycles ago
  int fc;                   // cycle index within the synthetic raster

  always #5 clk = ~clk;

  game_controller dut (
    .clk           (clk),
    .reset         (reset),
    .h_counter     (h_counter),
    .v_counter     (v_counter),
    .btn_start     (btn_start),
    .hit_alien     (hit_alien),
    .player_hit    (player_hit),
    .aliens_landed (aliens_landed),
    .wave_cleared  (wave_cleared),
    .state         (state),
    .game_active   (game_active),
    .freeze        (freeze),
    .frame_tick    (frame_tick),
    .march_step    (march_step),
    .wave_reset    (wave_reset),
    .lives         (lives),
    .pontuacao     (pontuacao),
    .record        (record)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",       32'(state),       32'(m_state));
    chk("game_active", 32'(game_active), 32'(m_state == 1));
    chk("freeze",      32'(freeze),      32'(m_state == 2));
    chk("frame_tick",  32'(frame_tick),  32'(m_tick));
    chk("march_step",  32'(march_step),  32'(m_step));
    chk("wave_reset",  32'(wave_reset),  32'(m_wr));
    chk("lives",       32'(lives),       32'(m_lives));
    chk("pontuacao",   32'(pontuacao),   32'(m_score));
    chk("record",      32'(record),      32'(m_rec));
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_rec = 0; m_lives = 3; m_kills = 0;
    m_period = 32; m_since = 0; m_dframes = 0;
    m_tick = 0; m_step = 0; m_wr = 0;
    bh1 = 0; bh2 = 0; bh3 = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    btn_start = 1'b0; hit_alien = 1'b0; player_hit = 1'b0;
    aliens_landed = 1'b0; wave_cleared = 1'b0;
    h_counter = 10'd1; v_counter = 10'd0;
    repeat (n) begin
      @(posedge clk); #1;
      model_reset();
      check_all();
    end
    reset = 1'b0;
    fc = 2;
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input bit b, input bit hit, input bit ph, input bit al, input bit wc);
    bit start, n_tick, n_step, n_wr;
    if ((fc % FP) < 2) begin
      v_counter = 10'd480; h_counter = 10'd0;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin v_counter = 10'd480; h_counter = 10'($urandom_range(1, 799)); end
        1:       begin v_counter = 10'($urandom_range(0, 479)); h_counter = 10'd0; end
        default: begin v_counter = 10'($urandom_range(0, 524)); h_counter = 10'($urandom_range(1, 799)); end
      endcase
    end
    btn_start = b; hit_alien = hit; player_hit = ph; aliens_landed = al; wave_cleared = wc;

    n_tick = ((fc % FP) == 0);
    start  = bh2 && !bh3;
    n_step = 0;
    n_wr   = 0;
    case (m_state)
      0, 3: begin
        if (m_state == 3 && m_score > m_rec) m_rec = m_score;
        if (start) begin
          m_state = 1; m_score = 0; m_lives = 3; m_kills = 0;
          m_period = 32; m_since = 0; n_wr = 1;
        end
      end
      1: begin
        if (m_tick) begin
          if (m_since + 1 >= m_period) begin n_step = 1; m_since = 0; end
          else m_since++;
        end
        if (hit) begin
          m_score = (m_score + 10 > 999) ? 999 : m_score + 10;
          m_kills++;
          if (m_kills == 8) begin
            m_kills  = 0;
            m_period = (m_period - 2 < 4) ? 4 : m_period - 2;
          end
        end
        if (wc) begin n_wr = 1; m_period = 32; m_since = 0; m_kills = 0; end
        if (al) begin m_lives = 0; m_state = 3; end
        else if (ph) begin m_lives--; m_state = 2; m_dframes = 0; end
      end
      default: begin
        if (m_tick) begin
          m_dframes++;
          if (m_dframes == 60) begin
            if (m_lives == 0) m_state = 3;
            else begin m_state = 1; m_since = 0; end
          end
        end
      end
    endcase
    m_tick = n_tick; m_step = n_step; m_wr = n_wr;
    bh3 = bh2; bh2 = bh1; bh1 = b;
    fc++;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic press();
    repeat (4) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int cnt;
    int w;
    bit b;
    reset = 1'b1;
    do_reset(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_lives", 32'(lives), 32'd3);

    // Frame ticks over three frames.
    cnt = 0;
    repeat (30) begin
      cyc(0, 0, 0, 0, 0);
      if (frame_tick === 1'b1) cnt++;
    end
    chk("frame_count", 32'(cnt), 32'd3);

    // Button held for 100 cycles gives a single start.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (wave_reset === 1'b1) cnt++;
      if (i == 2) chk("start_latency", 32'(state), 32'd1);
    end
    chk("start_once", 32'(cnt), 32'd1);
    cyc(0, 0, 0, 0, 0);

    // 120 hits: score saturates, march period bottoms out.
    for (int i = 0; i < 120; i++) begin
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      if (i == 99) chk("score_sat", 32'(pontuacao), 32'd999);
    end
    w = 0;
    while (march_step !== 1'b1 && w < 400) begin cyc(0, 0, 0, 0, 0); w++; end
    chk("step_seen", 32'(march_step), 32'd1);
    cnt = 0;
    do begin cyc(0, 0, 0, 0, 0); cnt++; end while (march_step !== 1'b1 && cnt < 400);
    chk("min_period", 32'(cnt), 32'd40);

    // Three deaths from a clean record.
    do_reset(2);
    press();
    chk("new_game", 32'(state), 32'd1);
    repeat (15) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
    chk("score_150", 32'(pontuacao), 32'd150);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0);
      chk("dying", 32'(state), 32'd2);
      chk("lives_dec", 32'(lives), 32'(2 - k));
      w = 0;
      while (state === 2'd2 && w < 700) begin cyc(0, 0, 0, 0, 0); w++; end
      if (k < 2) chk("revive", 32'(state), 32'd1);
    end
    chk("over", 32'(state), 32'd3);
    chk("over_lives", 32'(lives), 32'd0);
    chk("record_late", 32'(record), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("record_set", 32'(record), 32'd150);

    // Simultaneous events.
    press();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    chk("landed_state", 32'(state), 32'd3);
    chk("landed_lives", 32'(lives), 32'd0);
    chk("landed_score", 32'(pontuacao), 32'd20);
    press();
    cyc(0, 0, 1, 0, 1);
    chk("hit_wave_state", 32'(state), 32'd2);
    chk("hit_wave_reset", 32'(wave_reset), 32'd1);

    // Reset while dying clears everything including the record.
    idle(5);
    do_reset(1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_record", 32'(record), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);

    // Randomized traffic.
    b = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) b = ~b;
      cyc(b,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 149) == 0,
          $urandom_range(0, 799) == 0,
          $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
